// File: rtl/pixel_coord_stepper.sv
// Raster-order complex-coordinate streamer: per-frame step sizes come from two serial
// dividers, then one adder per axis per pixel. Define PIXEL_STEPPER_ROUND_EN for round-to-nearest steps.
module pixel_coord_stepper #(
  parameter int WORD_LENGTH = 64,
  parameter int FRAC        = 60,
  parameter int XY_W        = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [XY_W-1:0]        screen_width_i,
  input  logic [XY_W-1:0]        screen_height_i,
  input  logic [31:0]            zoom_i,
  input  logic [WORD_LENGTH-1:0] real_center_i,
  input  logic [WORD_LENGTH-1:0] imag_center_i,
  output logic                   busy_o,
  output logic                   cfg_err_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XY_W-1:0]        out_x_o,
  output logic [XY_W-1:0]        out_y_o,
  output logic [WORD_LENGTH-1:0] out_real_o,
  output logic [WORD_LENGTH-1:0] out_imag_o,
  output logic                   out_last_o,
  output logic                   frame_done_o
);

  if (FRAC > WORD_LENGTH - 3) begin : g_bad_frac
    $error("pixel_coord_stepper: FRAC must not exceed WORD_LENGTH-3");
  end

  localparam int WL    = WORD_LENGTH;
  localparam int DVS_W = 32 + XY_W;
`ifdef PIXEL_STEPPER_ROUND_EN
  localparam int DW    = FRAC + 3;
`else
  localparam int DW    = FRAC + 2;
`endif
  localparam int CNT_W = $clog2(DW + 1);

  localparam logic [DW-1:0] DVD_RE_BASE = DW'(3) << FRAC;
  localparam logic [DW-1:0] DVD_IM_BASE = DW'(2) << FRAC;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DIV    = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_err_q, cfg_err_d;
  logic [XY_W-1:0]  width_q, width_d, height_q, height_d;
  logic [31:0]      zoom_q, zoom_d;
  logic [WL-1:0]    rc_q, rc_d, ic_q, ic_d;
  logic [DVS_W-1:0] dvs_re_q, dvs_re_d, dvs_im_q, dvs_im_d;
  logic [DVS_W-1:0] rem_re_q, rem_re_d, rem_im_q, rem_im_d;
  // The dividend shifts out of the MSB while quotient bits shift into the LSB,
  // so after DW steps these registers hold the step sizes.
  logic [DW-1:0]    dvd_re_q, dvd_re_d, dvd_im_q, dvd_im_d;
  logic [WL-1:0]    real_min_q, real_min_d;
  logic [WL-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [XY_W-1:0]  x_q, x_d, y_q, y_d;

  logic [DVS_W-1:0] prod_re, prod_im;
  logic [WL-1:0]    step_re, step_im, span_re, span_im, real_min_c, imag_max_c;
  logic [DVS_W:0]   res_re, res_im;
  logic             xfer, x_end, y_end;

  function automatic logic [DVS_W:0] div_step(input logic [DVS_W-1:0] rem,
                                              input logic             msb,
                                              input logic [DVS_W-1:0] dvs);
    logic [DVS_W+1:0] sh;
    logic [DVS_W+1:0] diff;
    sh   = {1'b0, rem, msb};
    diff = sh - {2'b00, dvs};
    if (diff[DVS_W+1]) return {sh[DVS_W-1:0], 1'b0};
    else               return {diff[DVS_W-1:0], 1'b1};
  endfunction

  assign prod_re = DVS_W'(zoom_q) * DVS_W'(width_q);
  assign prod_im = DVS_W'(zoom_q) * DVS_W'(height_q);
  assign res_re  = div_step(rem_re_q, dvd_re_q[DW-1], dvs_re_q);
  assign res_im  = div_step(rem_im_q, dvd_im_q[DW-1], dvs_im_q);

  assign step_re    = WL'(dvd_re_q);
  assign step_im    = WL'(dvd_im_q);
  assign span_re    = step_re * WL'(width_q);
  assign span_im    = step_im * WL'(height_q);
  assign real_min_c = rc_q - {span_re[WL-1], span_re[WL-1:1]};
  assign imag_max_c = ic_q + {span_im[WL-1], span_im[WL-1:1]};

  assign x_end = (x_q == width_q - XY_W'(1));
  assign y_end = (y_q == height_q - XY_W'(1));
  assign xfer  = (state_q == S_STREAM) && out_ready_i;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_err_d  = 1'b0;
    width_d    = width_q;
    height_d   = height_q;
    zoom_d     = zoom_q;
    rc_d       = rc_q;
    ic_d       = ic_q;
    dvs_re_d   = dvs_re_q;
    dvs_im_d   = dvs_im_q;
    rem_re_d   = rem_re_q;
    rem_im_d   = rem_im_q;
    dvd_re_d   = dvd_re_q;
    dvd_im_d   = dvd_im_q;
    real_min_d = real_min_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    x_d        = x_q;
    y_d        = y_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          width_d  = screen_width_i;
          height_d = screen_height_i;
          zoom_d   = zoom_i;
          rc_d     = real_center_i;
          ic_d     = imag_center_i;
          if (zoom_i == '0 || screen_width_i == '0 || screen_height_i == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = S_DIV;
            cnt_d   = '0;
          end
        end
      end
      S_DIV: begin
        if (cnt_q == '0) begin
          // First DIV cycle registers the divisors from the latched config.
          dvs_re_d = prod_re;
          dvs_im_d = prod_im;
          rem_re_d = '0;
          rem_im_d = '0;
`ifdef PIXEL_STEPPER_ROUND_EN
          dvd_re_d = DVD_RE_BASE + DW'(prod_re >> 1);
          dvd_im_d = DVD_IM_BASE + DW'(prod_im >> 1);
`else
          dvd_re_d = DVD_RE_BASE;
          dvd_im_d = DVD_IM_BASE;
`endif
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          rem_re_d = res_re[DVS_W:1];
          rem_im_d = res_im[DVS_W:1];
          dvd_re_d = {dvd_re_q[DW-2:0], res_re[0]};
          dvd_im_d = {dvd_im_q[DW-2:0], res_im[0]};
          if (cnt_q == CNT_W'(DW)) state_d = S_SETUP;
          else                     cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_SETUP: begin
        real_min_d = real_min_c;
        acc_re_d   = real_min_c;
        acc_im_d   = imag_max_c;
        x_d        = '0;
        y_d        = '0;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        if (xfer) begin
          if (!x_end) begin
            x_d      = x_q + XY_W'(1);
            acc_re_d = acc_re_q + step_re;
          end else begin
            x_d      = '0;
            acc_re_d = real_min_q;
            y_d      = y_q + XY_W'(1);
            acc_im_d = acc_im_q - step_im;
            if (y_end) state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_err_q  <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
      zoom_q     <= '0;
      rc_q       <= '0;
      ic_q       <= '0;
      dvs_re_q   <= '0;
      dvs_im_q   <= '0;
      rem_re_q   <= '0;
      rem_im_q   <= '0;
      dvd_re_q   <= '0;
      dvd_im_q   <= '0;
      real_min_q <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_err_q  <= cfg_err_d;
      width_q    <= width_d;
      height_q   <= height_d;
      zoom_q     <= zoom_d;
      rc_q       <= rc_d;
      ic_q       <= ic_d;
      dvs_re_q   <= dvs_re_d;
      dvs_im_q   <= dvs_im_d;
      rem_re_q   <= rem_re_d;
      rem_im_q   <= rem_im_d;
      dvd_re_q   <= dvd_re_d;
      dvd_im_q   <= dvd_im_d;
      real_min_q <= real_min_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign cfg_err_o    = cfg_err_q;
  assign out_valid_o  = (state_q == S_STREAM);
  assign out_last_o   = (state_q == S_STREAM) && x_end && y_end;
  assign frame_done_o = (state_q == S_DONE);
  assign out_x_o      = x_q;
  assign out_y_o      = y_q;
  assign out_real_o   = acc_re_q;
  assign out_imag_o   = acc_im_q;

endmodule

// File: doc/pixel_coord_stepper.md
# pixel_coord_stepper

Streaming, divider-free-per-pixel successor to the combinational pixel mapper. On `start` it latches one frame's view configuration and computes per-pixel real/imaginary step sizes once, with a serial divider. It then emits every pixel's complex coordinate in raster order over a valid/ready stream. It sits between the frame controller and the Mandelbrot iteration engines and replaces the two per-pixel dividers with one adder per axis.

## Interface
- `WORD_LENGTH`, 64: width of the signed fixed-point coordinate.
- `FRAC`, 60: fractional bits; legal when `FRAC <= WORD_LENGTH-3` (elaboration `$error` otherwise).
- `XY_W`, 11: pixel index / screen dimension width.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `abort` in 1: cancel the current frame.
- `screen_width` in XY_W: pixels per line, unsigned.
- `screen_height` in XY_W: lines per frame, unsigned.
- `zoom` in 32: unsigned zoom factor.
- `real_center` in WORD_LENGTH: signed Q(WORD_LENGTH-FRAC).FRAC.
- `imag_center` in WORD_LENGTH: signed, same format.
- `busy` out 1: high in any state other than IDLE.
- `cfg_err` out 1: one-cycle pulse when `start` is rejected.
- `out_valid` out 1: coordinate available.
- `out_ready` in 1: consumer accepts.
- `out_x`, `out_y` out XY_W: pixel index of the current beat.
- `out_real`, `out_imag` out WORD_LENGTH: signed coordinate.
- `out_last` out 1: high on the final pixel of the frame.
- `frame_done` out 1: one-cycle pulse after the last transfer.

## Operation
- **IDLE**: `start`=1 latches all config inputs.
  - If `zoom`, `screen_width` or `screen_height` is 0: pulse `cfg_err` and stay in IDLE.
  - Otherwise go to DIV.
- **DIV**: two parallel restoring dividers, one quotient bit per cycle, FRAC+2 cycles.
  - `real_step = floor(3·2^FRAC / (zoom·screen_width))`.
  - `imag_step = floor(2·2^FRAC / (zoom·screen_height))`.
  - Divisors are 32+XY_W bits unsigned. The quotient always fits WORD_LENGTH and is non-negative.
- **SETUP** (1 cycle):
  - `real_min = real_center − ((real_step·screen_width) >>> 1)`.
  - `imag_max = imag_center + ((imag_step·screen_height) >>> 1)`.
  - Products are truncated to WORD_LENGTH with wrap-around, no saturation.
  - Load the accumulators `acc_re = real_min`, `acc_im = imag_max`, x=y=0.
- **STREAM**: present `out_real=acc_re`, `out_imag=acc_im`. On each transfer (`out_valid && out_ready`):
  - If x < W−1: x+1, `acc_re += real_step`.
  - Else: x=0, `acc_re=real_min`, y+1, `acc_im −= imag_step`.
  - On the transfer with x=W−1 and y=H−1 (`out_last`=1): go to DONE.
- **DONE** (1 cycle): `frame_done`=1, then go to IDLE.
- Outputs are identical to the direct form `real_min + x·real_step`, `imag_max − y·imag_step`, modulo 2^WORD_LENGTH.
- `abort` in any non-IDLE state: go to IDLE on the next edge and drop `out_valid`. No `frame_done` is issued. Takes priority over a simultaneous transfer.
- `start` while `busy`=1 is ignored. Config input changes after latching have no effect until the next `start`.
- `rst` (any time, including mid-frame): state=IDLE. All outputs are 0: `busy`, `cfg_err`, `out_valid`, `out_last`, `frame_done`, `out_x`, `out_y`, `out_real`, `out_imag`. All internal registers are cleared.

## Timing
- Let the edge that samples an accepted `start` be edge 0. `busy`=1 after edge 0.
- `out_valid` first rises after edge FRAC+4.
- Streaming rate: one pixel per cycle while `out_ready`=1.
- Frame with W·H pixels and no backpressure: `frame_done` is high for the cycle after the last transfer edge. `busy` falls one cycle later.
- Backpressure: while `out_valid && !out_ready`, `out_x`, `out_y`, `out_real`, `out_imag` and `out_last` hold stable. `out_valid` never drops without a transfer, except on `abort` or `rst`.
- `cfg_err` is high for exactly the cycle after the rejecting edge.
- 1×1 frame: the single beat has `out_last`=1.

## Configuration
- Macro `PIXEL_STEPPER_ROUND_EN`.
- Defined: both divisions round to nearest. Half the divisor is added to the dividend before dividing, so the dividend is FRAC+3 bits and DIV lasts FRAC+3 cycles. First `out_valid` moves to after edge FRAC+5.
- Undefined: truncating division as specified above.

## Test plan
- **Base frame.** WORD_LENGTH=64, FRAC=60, W=4, H=2, zoom=1, centers 0, `out_ready`=1.
  - Pixel (0,0): real=0xE800_0000_0000_0000 (−1.5), imag=0x1000_0000_0000_0000 (+1.0).
  - Pixel (3,1): real=0x0C00_0000_0000_0000 (+0.75), imag=0, `out_last`=1.
  - 8 beats, then `frame_done`. First valid after edge 64.
- **Backpressure.** Same config, `out_ready` toggled randomly → beat sequence identical to the base frame; outputs stable while stalled.
- **Rejected start.** `zoom`=0 with `start` → `cfg_err` pulse, `busy` stays 0, no `out_valid`.
- **Abort.** Assert `abort` at beat 3, then restart with real_center=0x0800_0000_0000_0000 → first beat real=0xF000_0000_0000_0000 (−1.0) and no `frame_done` for the aborted frame.
- **Reset mid-stream.** Assert `rst` during STREAM → all outputs 0 immediately (asynchronous). A new `start` behaves exactly as the base frame.
- **Rounding / equivalence.** W=3, zoom=7 with `PIXEL_STEPPER_ROUND_EN` defined vs undefined → `real_step` equals round vs floor of 3·2^60/21. Every beat matches the direct-form golden model for its build.
